// File: rtl/mura_prog_if.sv
// mura_prog_if: step/request inputs, table-programming port and observation outputs of mura_prog.
interface mura_prog_if #(parameter int IN_W = 4, parameter int ST_W = 2, parameter int OUT_W = 2);
  localparam int SEL_W = $clog2(IN_W + 1);
  logic             step;
  logic [IN_W-1:0]  a;
  logic             cfg_we;
  logic             cfg_kind;
  logic [ST_W-1:0]  cfg_state;
  logic [SEL_W-1:0] cfg_sel;
  logic [ST_W-1:0]  cfg_next;
  logic [OUT_W-1:0] cfg_out;
  logic [OUT_W-1:0] y;
  logic [ST_W-1:0]  state_o;
  logic             moved;
  logic [15:0]      trans_cnt;
  logic [ST_W-1:0]  last_from;
  logic [ST_W-1:0]  last_to;
  modport master (output step, a, cfg_we, cfg_kind, cfg_state, cfg_sel, cfg_next, cfg_out,
                  input y, state_o, moved, trans_cnt, last_from, last_to);
  modport slave  (input step, a, cfg_we, cfg_kind, cfg_state, cfg_sel, cfg_next, cfg_out,
                  output y, state_o, moved, trans_cnt, last_from, last_to);
endinterface

// File: rtl/mura_prog.sv
// mura_prog: programmable Moore FSM with priority-encoded request inputs and runtime-writable tables.
// Optional trace counters/endpoints enabled by defining MURA_TRACE_EN.
module mura_prog #(
  parameter int IN_W  = 4,
  parameter int ST_W  = 2,
  parameter int OUT_W = 2
) (
  input logic clk,
  input logic rst,
  mura_prog_if.slave b
);
  localparam int SEL_W = $clog2(IN_W + 1);
  localparam int NS = 2 ** ST_W;
  logic [ST_W-1:0]  nxt_tbl [NS][IN_W+1];
  logic [OUT_W-1:0] out_tbl [NS];
  logic [ST_W-1:0]  state, nxt;
  logic [SEL_W-1:0] win;
  logic             moved;
  always_ff @(posedge clk) begin
    state <= rst ? '0 : nxt;
    moved <= !rst && nxt != state;
  end
  always_comb begin
    win = SEL_W'(IN_W);
    for (int i = IN_W - 1; i >= 0; i--) win = b.a[i] ? SEL_W'(i) : win;
    nxt = b.step ? nxt_tbl[state][win] : state;
  end
  always_comb begin
    b.y       = out_tbl[state];
    b.state_o = state;
    b.moved   = moved;
  end
  // Writes land on the same edge as a step, so the step always sees the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NS; s++) begin
        out_tbl[s] <= OUT_W'(s == 0);
        for (int i = 0; i <= IN_W; i++) nxt_tbl[s][i] <= ST_W'(s);
      end
    end else if (b.cfg_we) begin
      if (b.cfg_kind) out_tbl[b.cfg_state] <= b.cfg_out;
      else if (b.cfg_sel <= SEL_W'(IN_W)) nxt_tbl[b.cfg_state][b.cfg_sel] <= b.cfg_next;
    end
  end
`ifdef MURA_TRACE_EN
  logic [15:0]     cnt;
  logic [ST_W-1:0] lf, lt;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      lf  <= '0;
      lt  <= '0;
    end else if (nxt != state) begin
      cnt <= cnt + 16'(cnt != 16'hFFFF);
      lf  <= state;
      lt  <= nxt;
    end
  end
  assign b.trans_cnt = cnt;
  assign b.last_from = lf;
  assign b.last_to   = lt;
`else
  assign b.trans_cnt = '0;
  assign b.last_from = '0;
  assign b.last_to   = '0;
`endif
endmodule

// File: tb/tb_mura_prog.sv
// tb_mura_prog: directed scenarios plus random traffic against a table-level reference model.
module tb_mura_prog;
  localparam int IN_W = 4, ST_W = 2, OUT_W = 2;
`ifdef MURA_TRACE_EN
  localparam bit TR = 1;
`else
  localparam bit TR = 0;
`endif
  logic clk = 0, rst;
  always #5 clk = ~clk;
  mura_prog_if #(.IN_W(IN_W), .ST_W(ST_W), .OUT_W(OUT_W)) b();
  mura_prog #(.IN_W(IN_W), .ST_W(ST_W), .OUT_W(OUT_W)) dut (.clk(clk), .rst(rst), .b(b));
  int n = 0, nerr = 0;
  int ms, mmoved, mcnt, mlf, mlt;
  int mt [4][5];
  int mo [4];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input bit r, input bit st, input int av, input bit we, input bit kind,
                     input int cs, input int sel, input int cn, input int co);
    int w, ns;
    rst = r;
    b.step = st;
    b.a = IN_W'(av);
    b.cfg_we = we;
    b.cfg_kind = kind;
    b.cfg_state = ST_W'(cs);
    b.cfg_sel = 3'(sel);
    b.cfg_next = ST_W'(cn);
    b.cfg_out = OUT_W'(co);
    @(posedge clk);
    w = 0;
    while (w < IN_W && !av[w]) w++;
    if (r) begin
      ms = 0; mmoved = 0; mcnt = 0; mlf = 0; mlt = 0;
      for (int s = 0; s < 4; s++) begin
        mo[s] = (s == 0) ? 1 : 0;
        for (int i = 0; i <= IN_W; i++) mt[s][i] = s;
      end
    end else begin
      ns = st ? mt[ms][w] : ms;
      mmoved = (ns != ms);
      if (mmoved) begin
        if (mcnt < 65535) mcnt++;
        mlf = ms;
        mlt = ns;
      end
      ms = ns;
      if (we) begin
        if (kind) mo[cs] = co;
        else if (sel <= IN_W) mt[cs][sel] = cn;
      end
    end
    #1;
    chk("state", 32'(b.state_o), 32'(ms));
    chk("y", 32'(b.y), 32'(mo[ms]));
    chk("moved", 32'(b.moved), 32'(mmoved));
    chk("trans_cnt", 32'(b.trans_cnt), TR ? 32'(mcnt) : 0);
    chk("last_from", 32'(b.last_from), TR ? 32'(mlf) : 0);
    chk("last_to", 32'(b.last_to), TR ? 32'(mlt) : 0);
  endtask
  task automatic do_rst();
    cyc(1, 1, 15, 1, 0, 0, 0, 3, 3);
  endtask
  task automatic wr_n(input int s, input int i, input int nx);
    cyc(0, 0, 0, 1, 0, s, i, nx, 0);
  endtask
  task automatic wr_o(input int s, input int o);
    cyc(0, 0, 0, 1, 1, s, 0, 0, o);
  endtask
  task automatic stp(input int av);
    cyc(0, 1, av, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    do_rst();
    do_rst();
    chk("reset_y", 32'(b.y), 32'd1);
    for (int k = 0; k < 3; k++) stp(4'b0101);
    wr_n(0, 2, 1); wr_n(1, 4, 2); wr_o(1, 2); wr_o(2, 3);
    stp(4'b0100);
    chk("r18_y1", 32'(b.y), 32'd2);
    stp(0);
    chk("r18_state", 32'(b.state_o), 32'd2);
    chk("r18_y2", 32'(b.y), 32'd3);
    do_rst();
    wr_n(0, 0, 3); wr_n(0, 1, 1);
    cyc(0, 0, 15, 0, 0, 0, 0, 0, 0);
    stp(4'b1111);
    chk("r19_state", 32'(b.state_o), 32'd3);
    do_rst();
    cyc(0, 1, 4'b1000, 1, 0, 0, 3, 2, 0);
    chk("r20_old_tbl", 32'(b.state_o), 32'd0);
    stp(4'b1000);
    chk("r20_new_tbl", 32'(b.state_o), 32'd2);
    for (int sl = 5; sl < 8; sl++) wr_n(2, sl, 1);
    stp(0); stp(1); stp(4'b1000);
    do_rst();
    for (int s = 0; s < 4; s++) wr_n(s, 4, (s + 1) % 4);
    wr_o(3, 2);
    stp(0); stp(1); stp(0); stp(1); stp(0); stp(0); stp(1); stp(0);
    chk("r21_cnt", 32'(b.trans_cnt), TR ? 32'd5 : 32'd0);
    chk("r21_to", 32'(b.last_to), TR ? 32'd1 : 32'd0);
    do_rst();
    stp(0);
    chk("r21_tbl_reset", 32'(b.state_o), 32'd0);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 59) == 0) do_rst();
      else cyc(0, 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
               1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n, nerr);
    $finish;
  end
endmodule

// File: doc/mura_prog.md
MURA_PROG -- requirements
Module: mura_prog

Interface
REQ-001 Parameters SHALL be: IN_W, default 4, number of input request lines; ST_W, default 2, state index width (2**ST_W states); OUT_W, default 2, Moore output width; SEL_W = clog2(IN_W+1), derived, not overridable.
REQ-002 Ports SHALL be exactly as follows:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- step  in  1  advance enable; the state register updates only in cycles with step=1.
- a  in  IN_W  input requests; a[0] has highest priority.
- cfg_we  in  1  table write strobe.
- cfg_kind  in  1  0 = transition-table entry, 1 = output-table entry.
- cfg_state  in  ST_W  state being programmed.
- cfg_sel  in  SEL_W  input index 0..IN_W-1, or IN_W for "no input active"; ignored when cfg_kind=1.
- cfg_next  in  ST_W  next-state value written (cfg_kind=0).
- cfg_out  in  OUT_W  output value written (cfg_kind=1).
- y  out  OUT_W  Moore output, equal to out_tbl[state].
- state_o  out  ST_W  current state.
- moved  out  1  registered; 1 for one cycle after a step that changed the state.
- trans_cnt  out  16  state-change count (see Configuration).
- last_from, last_to  out  ST_W each  endpoints of the most recent state change (see Configuration).

Function
REQ-003 Input priority SHALL be: win = lowest index i with a[i]=1; win = IN_W when a is all zero.
REQ-004 On a rising edge with step=1, state SHALL load nxt_tbl[state][win]; with step=0, state SHALL hold.
REQ-005 y SHALL be a combinational function of registered state and out_tbl only, with no path from a or step; y SHALL change only in the cycle after the state or the addressed out_tbl entry changes.
REQ-006 moved SHALL be set to 1 on an edge where step=1 and the new state differs from the old state, and cleared to 0 on every other edge.
REQ-007 A cfg_we=1 write SHALL take effect at the edge on which it is sampled; a step in the same cycle SHALL use the pre-write table contents.
REQ-008 A write to out_tbl[state] for the current state SHALL be visible on y in the following cycle.
REQ-009 A write with cfg_kind=0 and cfg_sel > IN_W SHALL be ignored, with no table change.
REQ-010 A self-loop transition (next equals current) SHALL hold the state, leave moved=0, and leave the trace registers unchanged.
REQ-011 A write to the transition table while step=0 SHALL NOT change the state.

Reset
REQ-012 With rst=1 at an edge, the block SHALL set state=0, moved=0, trans_cnt=0, last_from=0, and last_to=0.
REQ-013 With rst=1 at an edge, the block SHALL set every nxt_tbl[s][i] to s (hold everywhere), out_tbl[0] to 1, and every other out_tbl entry to 0.
REQ-014 rst SHALL take priority over step and cfg_we in the same cycle, and a reset mid-operation SHALL discard all programming.

Configuration
REQ-015 Macro MURA_TRACE_EN, when defined, SHALL enable the trace function: trans_cnt increments, saturating at 16'hFFFF, on each edge that sets moved, and last_from/last_to capture the old and new state on that edge.
REQ-016 When MURA_TRACE_EN is undefined, trans_cnt, last_from and last_to SHALL be tied to 0, with no trace registers inferred; all other behaviour SHALL be unchanged.

Verification
REQ-017 Reset, then step=1 with a=4'b0101 for 3 cycles and no programming -> state_o=0 throughout, y=2'b01, moved=0.
REQ-018 Program nxt[0][2]=1, nxt[1][IN_W]=2, out[1]=2'b10, out[2]=2'b11; a=4'b0100 with step for 1 cycle, then a=0 with step for 1 cycle -> state 0->1->2, y 01->10->11, moved pulses for each step.
REQ-019 a=4'b1111 with nxt[0][0]=3 and nxt[0][1]=1 -> state goes to 3 (a[0] wins); with step=0 the same stimulus leaves state unchanged.
REQ-020 Write nxt[0][3]=2 in the same cycle as step with a=4'b1000 -> state stays 0 (old table); the next step gives state 2.
REQ-021 With MURA_TRACE_EN defined: 5 state changes interleaved with 3 self-loops -> trans_cnt=5, last_from/last_to match the final change; assert rst -> all trace outputs and the tables return to reset values.
REQ-022 With MURA_TRACE_EN undefined: the same run as REQ-021 -> trans_cnt, last_from and last_to stay 0 throughout.
